// File: rtl/trace_pkg.sv
// Shared types and widths for the saber trail scheduler.
// Contents: FSM state enum, coordinate widths, saber count, counter width,
// sample payload struct and a saturating increment helper.
package trace_pkg;

   localparam int unsigned X_W     = 12;
   localparam int unsigned Y_W     = 11;
   localparam int unsigned N_SABER = 2;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned FRAME_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_NEXT  = 2'd2
   } state_e;

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
   } pos_t;

   // Increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/trace_scheduler_if.sv
// Sample/push bus of the trail scheduler.
// Signals: nf_in (new-frame pulse), s_valid_in/s_x_in/s_y_in (per-saber
// samples, index 0 = saber A, 1 = saber B), push_valid_out/push_id_out/
// push_x_out/push_y_out (push offered to trail histories), push_ready_in.
// Modports: master = sample source / trail sink side, slave = scheduler.
interface trace_scheduler_if;
   import trace_pkg::*;

   logic                            nf_in;
   logic [N_SABER-1:0]              s_valid_in;
   logic [N_SABER-1:0][X_W-1:0]     s_x_in;
   logic [N_SABER-1:0][Y_W-1:0]     s_y_in;
   logic                            push_valid_out;
   logic                            push_id_out;
   logic [X_W-1:0]                  push_x_out;
   logic [Y_W-1:0]                  push_y_out;
   logic                            push_ready_in;

   modport master (
      output nf_in, s_valid_in, s_x_in, s_y_in, push_ready_in,
      input  push_valid_out, push_id_out, push_x_out, push_y_out
   );

   modport slave (
      input  nf_in, s_valid_in, s_x_in, s_y_in, push_ready_in,
      output push_valid_out, push_id_out, push_x_out, push_y_out
   );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: prefers the requester named by rr, else the
// other one. Ports: rr (preferred id), req (request bits), id_c (chosen id),
// any_c (at least one request).
module rr_pick2 (
   input  logic       rr,
   input  logic [1:0] req,
   output logic       id_c,
   output logic       any_c
);

   assign any_c = |req;
   assign id_c  = req[rr] ? rr : ~rr;

endmodule

// File: rtl/trace_scheduler.sv
// Trail scheduler: latches per-saber position samples and, on every
// DECIMATE-th new-frame pulse, pushes the scheduled sabers' positions one at a
// time to the trail histories, alternating which saber goes first.
// Ports: clk_in, rst_in (async active-low), bus (slave side of
// trace_scheduler_if), drop_count_out (overwritten samples, saturating),
// skip_count_out (ticks ignored while busy, saturating).
// Option: define TRACE_SCHED_HOLD_EN to also re-push the last accepted
// position of a saber that delivered no new sample.
module trace_scheduler
   import trace_pkg::*;
#(
   parameter int unsigned DECIMATE = 1
) (
   input  logic                clk_in,
   input  logic                rst_in,
   trace_scheduler_if.slave    bus,
   output logic [CNT_W-1:0]    drop_count_out,
   output logic [CNT_W-1:0]    skip_count_out
);

   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(DECIMATE - 1);

   state_e              state_q, state_d;
   pos_t                samp_q [N_SABER];
   logic [N_SABER-1:0]  pending_q;
   logic [N_SABER-1:0]  sched_q;
   logic                rr_q;
   logic [FRAME_W-1:0]  frame_q;

   logic                push_valid_q;
   logic                push_id_q;
   logic [X_W-1:0]      push_x_q;
   logic [Y_W-1:0]      push_y_q;

   logic                tick_c;
   logic                skip_c;
   logic [N_SABER-1:0]  req_c;
   logic                pick_id_c;
   logic                pick_any_c;
   logic                other_id_c;

   logic                load_c;
   logic                load_id_c;
   logic                capture_c;
   logic                done_c;
   logic                rr_flip_c;

   logic [N_SABER-1:0]  id_mask_c;
   logic [N_SABER-1:0]  clr_c;
   logic [N_SABER-1:0]  drop_hit_c;
   logic [CNT_W:0]      drop_sum_c;

   // Frame decimation: tick on the last frame of each DECIMATE group.
   assign tick_c = bus.nf_in && (frame_q == FRAME_LAST);
   assign skip_c = tick_c && (state_q != ST_IDLE);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         frame_q <= '0;
      end else if (bus.nf_in) begin
         frame_q <= tick_c ? '0 : frame_q + FRAME_W'(1);
      end
   end

   // Which sabers are eligible at a tick.
`ifdef TRACE_SCHED_HOLD_EN
   logic [N_SABER-1:0] has_last_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         has_last_q <= '0;
      end else begin
         has_last_q <= has_last_q | bus.s_valid_in;
      end
   end

   assign req_c = pending_q | has_last_q;
`else
   assign req_c = pending_q;
`endif

   rr_pick2 u_pick (
      .rr    (rr_q),
      .req   (req_c),
      .id_c  (pick_id_c),
      .any_c (pick_any_c)
   );

   assign other_id_c = ~push_id_q;

   // FSM state register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (tick_c && pick_any_c) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.push_ready_in) begin
               state_d = sched_q[other_id_c] ? ST_NEXT : ST_IDLE;
            end
         end
         ST_NEXT: begin
            state_d = ST_ISSUE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM control outputs.
   always_comb begin
      load_c    = 1'b0;
      load_id_c = pick_id_c;
      capture_c = 1'b0;
      done_c    = 1'b0;
      rr_flip_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick_c && pick_any_c) begin
               capture_c = 1'b1;
               load_c    = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (bus.push_ready_in) begin
               done_c    = 1'b1;
               rr_flip_c = !sched_q[other_id_c];
            end
         end
         ST_NEXT: begin
            load_c    = 1'b1;
            load_id_c = other_id_c;
         end
         default: begin
            load_c = 1'b0;
         end
      endcase
   end

   assign id_mask_c = load_id_c ? 2'b10 : 2'b01;

   // A sample arriving on the cycle its saber is loaded keeps pending set and
   // is not a drop: the older value is the one being pushed.
   always_comb begin
      clr_c      = '0;
      drop_hit_c = '0;
      for (int i = 0; i < N_SABER; i++) begin
         clr_c[i]      = load_c && (load_id_c == 1'(i));
         drop_hit_c[i] = bus.s_valid_in[i] && pending_q[i] && !clr_c[i];
      end
   end

   assign drop_sum_c = {1'b0, drop_count_out}
                     + (CNT_W+1)'(drop_hit_c[0])
                     + (CNT_W+1)'(drop_hit_c[1]);

   // Sample registers and pending flags.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < N_SABER; i++) begin
            samp_q[i] <= '0;
         end
         pending_q <= '0;
      end else begin
         for (int i = 0; i < N_SABER; i++) begin
            if (bus.s_valid_in[i]) begin
               samp_q[i] <= '{x: bus.s_x_in[i], y: bus.s_y_in[i]};
            end
         end
         pending_q <= bus.s_valid_in | (pending_q & ~clr_c);
      end
   end

   // Schedule set (ids still to push this tick) and round-robin pointer.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         sched_q <= '0;
         rr_q    <= 1'b0;
      end else begin
         if (capture_c) begin
            sched_q <= req_c & ~id_mask_c;
         end else if (load_c) begin
            sched_q <= sched_q & ~id_mask_c;
         end
         if (rr_flip_c) begin
            rr_q <= ~rr_q;
         end
      end
   end

   // Push output registers; held while waiting for push_ready_in.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         push_valid_q <= 1'b0;
         push_id_q    <= 1'b0;
         push_x_q     <= '0;
         push_y_q     <= '0;
      end else if (load_c) begin
         push_valid_q <= 1'b1;
         push_id_q    <= load_id_c;
         push_x_q     <= samp_q[load_id_c].x;
         push_y_q     <= samp_q[load_id_c].y;
      end else if (done_c) begin
         push_valid_q <= 1'b0;
      end
   end

   // Saturating event counters.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         drop_count_out <= '0;
         skip_count_out <= '0;
      end else begin
         drop_count_out <= drop_sum_c[CNT_W] ? '1 : drop_sum_c[CNT_W-1:0];
         if (skip_c) begin
            skip_count_out <= sat_inc(skip_count_out);
         end
      end
   end

   assign bus.push_valid_out = push_valid_q;
   assign bus.push_id_out    = push_id_q;
   assign bus.push_x_out     = push_x_q;
   assign bus.push_y_out     = push_y_q;

endmodule

// File: tb/tb_trace_scheduler.sv
// Directed bench for trace_scheduler: two instances (DECIMATE=1 and 3),
// hand-computed expectations, push handshakes tallied per instance.
module tb_trace_scheduler;
   import trace_pkg::*;

`ifdef TRACE_SCHED_HOLD_EN
   localparam int HOLD_PUSHES = 4;
`else
   localparam int HOLD_PUSHES = 1;
`endif

   logic             clk_in;
   logic             rst_n;
   logic [CNT_W-1:0] drop_a, skip_a, drop_b, skip_b;

   int               n_tests = 0;
   int               n_fail  = 0;

   int               pcnt_a = 0;
   int               pcnt_b = 0;
   logic             lid_a, lid_b;
   logic [X_W-1:0]   lx_a, lx_b;
   logic [Y_W-1:0]   ly_a, ly_b;
   int               base;

   trace_scheduler_if bus_a();
   trace_scheduler_if bus_b();

   trace_scheduler #(.DECIMATE(1)) u_a (
      .clk_in         (clk_in),
      .rst_in         (rst_n),
      .bus            (bus_a),
      .drop_count_out (drop_a),
      .skip_count_out (skip_a)
   );

   trace_scheduler #(.DECIMATE(3)) u_b (
      .clk_in         (clk_in),
      .rst_in         (rst_n),
      .bus            (bus_b),
      .drop_count_out (drop_b),
      .skip_count_out (skip_b)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Tally accepted pushes and remember the most recent one.
   always @(posedge clk_in) begin
      if (bus_a.push_valid_out && bus_a.push_ready_in) begin
         pcnt_a <= pcnt_a + 1;
         lid_a  <= bus_a.push_id_out;
         lx_a   <= bus_a.push_x_out;
         ly_a   <= bus_a.push_y_out;
      end
      if (bus_b.push_valid_out && bus_b.push_ready_in) begin
         pcnt_b <= pcnt_b + 1;
         lid_b  <= bus_b.push_id_out;
         lx_b   <= bus_b.push_x_out;
         ly_b   <= bus_b.push_y_out;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic samp_a(input logic [1:0] v, input logic [X_W-1:0] x0, input logic [Y_W-1:0] y0,
                         input logic [X_W-1:0] x1, input logic [Y_W-1:0] y1);
      bus_a.s_valid_in = v;
      bus_a.s_x_in[0]  = x0;
      bus_a.s_y_in[0]  = y0;
      bus_a.s_x_in[1]  = x1;
      bus_a.s_y_in[1]  = y1;
      cyc();
      bus_a.s_valid_in = 2'b00;
   endtask

   task automatic samp_b(input logic [X_W-1:0] x0, input logic [Y_W-1:0] y0,
                         input logic [X_W-1:0] x1, input logic [Y_W-1:0] y1);
      bus_b.s_valid_in = 2'b11;
      bus_b.s_x_in[0]  = x0;
      bus_b.s_y_in[0]  = y0;
      bus_b.s_x_in[1]  = x1;
      bus_b.s_y_in[1]  = y1;
      cyc();
      bus_b.s_valid_in = 2'b00;
   endtask

   task automatic nf_a();
      bus_a.nf_in = 1'b1;
      cyc();
      bus_a.nf_in = 1'b0;
   endtask

   task automatic nf_b();
      bus_b.nf_in = 1'b1;
      cyc();
      bus_b.nf_in = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n               = 1'b0;
      bus_a.nf_in         = 1'b0;
      bus_a.s_valid_in    = '0;
      bus_a.s_x_in        = '0;
      bus_a.s_y_in        = '0;
      bus_a.push_ready_in = 1'b1;
      bus_b.nf_in         = 1'b0;
      bus_b.s_valid_in    = '0;
      bus_b.s_x_in        = '0;
      bus_b.s_y_in        = '0;
      bus_b.push_ready_in = 1'b1;
      cyc(3);

      // Reset state.
      chk("rst_valid", 32'(bus_a.push_valid_out), 32'd0);
      chk("rst_drop",  32'(drop_a), 32'd0);
      chk("rst_skip",  32'(skip_a), 32'd0);
      chk("rst_x",     32'(bus_a.push_x_out), 32'd0);
      rst_n = 1'b1;
      cyc();

      // Both sabers, rr starts at A.
      samp_a(2'b11, 12'd100, 11'd200, 12'd300, 11'd50);
      nf_a();
      chk("t1_valid0", 32'(bus_a.push_valid_out), 32'd1);
      chk("t1_id0",    32'(bus_a.push_id_out), 32'd0);
      chk("t1_x0",     32'(bus_a.push_x_out), 32'd100);
      chk("t1_y0",     32'(bus_a.push_y_out), 32'd200);
      cyc();
      chk("t1_gap",    32'(bus_a.push_valid_out), 32'd0);
      cyc();
      chk("t1_valid1", 32'(bus_a.push_valid_out), 32'd1);
      chk("t1_id1",    32'(bus_a.push_id_out), 32'd1);
      chk("t1_x1",     32'(bus_a.push_x_out), 32'd300);
      chk("t1_y1",     32'(bus_a.push_y_out), 32'd50);
      cyc();
      chk("t1_end",    32'(bus_a.push_valid_out), 32'd0);
      chk("t1_pcnt",   32'(pcnt_a), 32'd2);

      // Next frame: B goes first.
      samp_a(2'b11, 12'd1, 11'd2, 12'd3, 11'd4);
      nf_a();
      chk("t1b_id0",   32'(bus_a.push_id_out), 32'd1);
      chk("t1b_x0",    32'(bus_a.push_x_out), 32'd3);
      chk("t1b_y0",    32'(bus_a.push_y_out), 32'd4);
      cyc(2);
      chk("t1b_id1",   32'(bus_a.push_id_out), 32'd0);
      chk("t1b_x1",    32'(bus_a.push_x_out), 32'd1);
      cyc();
      chk("t1b_pcnt",  32'(pcnt_a), 32'd4);
      chk("t1b_drop",  32'(drop_a), 32'd0);

      // Decimation by 3 with a sample every frame.
      for (int f = 1; f <= 6; f++) begin
         samp_b(12'(10*f), 11'(20*f), 12'(10*f+1), 11'(20*f+1));
         nf_b();
         cyc(5);
         if (f == 2) chk("dec_nopush", 32'(pcnt_b), 32'd0);
         if (f == 3) begin
            chk("dec_pcnt3", 32'(pcnt_b), 32'd2);
            chk("dec_drop3", 32'(drop_b), 32'd4);
         end
      end
      chk("dec_pcnt6", 32'(pcnt_b), 32'd4);
      chk("dec_drop6", 32'(drop_b), 32'd8);
      chk("dec_lid",   32'(lid_b), 32'd0);
      chk("dec_lx",    32'(lx_b), 32'd60);
      chk("dec_ly",    32'(ly_b), 32'd120);
      chk("dec_skip",  32'(skip_b), 32'd0);

      // Stall with a tick arriving mid-stall.
      do_reset();
      bus_a.push_ready_in = 1'b0;
      samp_a(2'b01, 12'd5, 11'd6, 12'd0, 11'd0);
      nf_a();
      chk("st_valid", 32'(bus_a.push_valid_out), 32'd1);
      base = pcnt_a;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) bus_a.nf_in = 1'b1;
         cyc();
         bus_a.nf_in = 1'b0;
         chk("st_hold_v", 32'(bus_a.push_valid_out), 32'd1);
         chk("st_hold_x", 32'({bus_a.push_id_out, bus_a.push_x_out, bus_a.push_y_out}),
             32'({1'b0, 12'd5, 11'd6}));
      end
      bus_a.push_ready_in = 1'b1;
      cyc();
      chk("st_release", 32'(bus_a.push_valid_out), 32'd0);
      cyc(3);
      chk("st_skip",   32'(skip_a), 32'd1);
      chk("st_pushes", 32'(pcnt_a - base), 32'd1);
      chk("st_idle",   32'(bus_a.push_valid_out), 32'd0);

      // One sample, then empty frames.
      do_reset();
      samp_a(2'b01, 12'd7, 11'd8, 12'd0, 11'd0);
      base = pcnt_a;
      repeat (4) begin
         nf_a();
         cyc(4);
      end
      chk("hold_pushes", 32'(pcnt_a - base), 32'(HOLD_PUSHES));
      chk("hold_lx",     32'(lx_a), 32'd7);
      chk("hold_ly",     32'(ly_a), 32'd8);

      // Reset in the middle of a stalled push.
      bus_a.push_ready_in = 1'b0;
      samp_a(2'b01, 12'd9, 11'd9, 12'd0, 11'd0);
      samp_a(2'b01, 12'd11, 11'd12, 12'd0, 11'd0);
      nf_a();
      chk("rm_valid", 32'(bus_a.push_valid_out), 32'd1);
      chk("rm_x",     32'(bus_a.push_x_out), 32'd11);
      chk("rm_drop",  32'(drop_a), 32'd1);
      nf_a();
      chk("rm_skip",  32'(skip_a), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rm_async_valid", 32'(bus_a.push_valid_out), 32'd0);
      chk("rm_async_drop",  32'(drop_a), 32'd0);
      chk("rm_async_skip",  32'(skip_a), 32'd0);
      chk("rm_async_x",     32'(bus_a.push_x_out), 32'd0);
      cyc(2);
      rst_n = 1'b1;
      base = pcnt_a;
      bus_a.push_ready_in = 1'b1;
      nf_a();
      cyc(3);
      chk("rm_nopush", 32'(pcnt_a - base), 32'd0);
      chk("rm_idle",   32'(bus_a.push_valid_out), 32'd0);
      samp_a(2'b01, 12'd13, 11'd14, 12'd0, 11'd0);
      nf_a();
      chk("rm_new_valid", 32'(bus_a.push_valid_out), 32'd1);
      chk("rm_new_x",     32'(bus_a.push_x_out), 32'd13);
      cyc();
      chk("rm_new_pcnt",  32'(pcnt_a - base), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/trace_scheduler.md
TRACE_SCHEDULER -- requirements
Module: trace_scheduler

Interface
REQ-001 SHALL have parameter DECIMATE, default 1, meaning frames per trail-update tick (range 1..255).
REQ-002 SHALL have port clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port nf_in  input  1  single-cycle new-frame pulse.
REQ-005 SHALL have ports s_valid_in  input  2, s_x_in  input  2x12, s_y_in  input  2x11: per-saber position sample; index 0 = saber A, 1 = saber B.
REQ-006 SHALL have ports push_valid_out  output  1, push_id_out  output  1, push_x_out  output  12, push_y_out  output  11: push offered to the per-saber trail histories.
REQ-007 SHALL have port push_ready_in  input  1: trail history accepts the offered push.
REQ-008 SHALL have ports drop_count_out  output  8 (overwritten samples, saturating) and skip_count_out  output  8 (frame ticks ignored while busy, saturating).

Function
REQ-009 SHALL hold one sample register per saber; s_valid_in[i] loads it and sets pending[i]; a sample arriving while pending[i] is set overwrites it (newest wins) and increments drop_count_out.
REQ-010 SHALL count nf_in pulses modulo DECIMATE; tick = nf_in while frame counter equals DECIMATE-1; DECIMATE=1 ticks on every nf_in.
REQ-011 SHALL implement FSM states IDLE, ISSUE, NEXT.
REQ-012 SHALL, in IDLE on tick with schedule set nonzero, capture sched[1:0], pick first id = rr if sched[rr] else the other, load push_* registers from that sample, clear its pending bit, and enter ISSUE the next cycle with push_valid_out=1.
REQ-013 SHALL keep push_id/x/y_out stable while push_valid_out=1 and push_ready_in=0.
REQ-014 SHALL, in ISSUE on push_ready_in=1, go to NEXT if the other id is in sched, else to IDLE with push_valid_out=0 and toggle rr.
REQ-015 SHALL, in NEXT, load the other id's sample, clear its pending bit, return to ISSUE (one idle cycle between pushes).
REQ-016 SHALL ignore a tick occurring in ISSUE or NEXT and increment skip_count_out; frame counter still advances.
REQ-017 SHALL, when s_valid_in[i] coincides with the load of id i, offer the old register value and leave the new sample pending.
REQ-018 SHALL saturate both counters at 255.
REQ-019 SHALL have latency of exactly 1 cycle from tick to push_valid_out=1.

Reset
REQ-020 SHALL, while rst_in=0, clear FSM to IDLE, pending, has_last, sched, rr, frame counter, both counters and all push_* outputs to 0, regardless of an in-flight push.
REQ-021 SHALL resume normal operation on the first clk_in edge after rst_in returns to 1.

Configuration
REQ-022 SHALL, with TRACE_SCHED_HOLD_EN defined, schedule id i at tick when pending[i] or has_last[i] (any sample ever accepted since reset), re-pushing the last position so a stationary saber's trail collapses.
REQ-023 SHALL, without TRACE_SCHED_HOLD_EN, schedule only pending ids; has_last logic is absent.

Structure
REQ-024 SHALL place the FSM state enum, X_W=12, Y_W=11 and the saber id count in shared package trace_pkg.
REQ-025 SHALL be a single module; sub-module rr_pick2 (two-way round-robin picker) is the one natural split.

Verification
REQ-026 SHALL cover: A sample (100,200), B sample (300,50), nf_in, ready=1 -> push id0 (100,200), idle cycle, push id1 (300,50); next frame with both -> id1 first.
REQ-027 SHALL cover: DECIMATE=3, sample each frame -> push only on every 3rd nf_in; drop_count_out counts 2 per tick per saber.
REQ-028 SHALL cover: push_ready_in held 0 for 5 cycles -> push_* stable, nf_in during stall -> skip_count_out=1, no extra push.
REQ-029 SHALL cover: HOLD_EN, one A sample then 3 empty frames -> 4 pushes of A's position; without HOLD_EN -> 1 push.
REQ-030 SHALL cover: rst_in low mid-ISSUE -> push_valid_out=0 asynchronously, all counters 0, no push after release until new sample+tick.
